// File: rtl/ternary_seq_ctrl.sv
// ternary_seq_ctrl: start/abort-controlled sequencer for the ternary
// matrix-vector datapath. Paces weight loading into the weight bank, then
// streams bit-serial input vectors into the multiplier under valid/ready
// flow control, flagging each completed vector and the end of a job.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      job start (IDLE only) / return to IDLE (highest priority)
//   cfg_out_len       active output rows, latched on accepted start
//   cfg_vec_count     vectors per job, 0 = run until abort
//   in_valid          input beat present
//   in_ready          beat accepted (LOAD and MULT)
//   load_en, load_beat  weight-bank write strobe and beat index
//   mult_en, mult_clr, bit_sel  multiplier strobe, accumulator clear, bit index
//   out_valid, done   vector complete / job complete pulses
//   busy, err         not idle / illegal-config start pulse
module ternary_seq_ctrl #(
    parameter int unsigned MAX_OUT_LEN  = 7,
    parameter int unsigned BIT_WIDTH    = 8,
    parameter int unsigned WEIGHT_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] cfg_out_len,
    input  logic [7:0] cfg_vec_count,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_en,
    output logic [3:0] load_beat,
    output logic       mult_en,
    output logic       mult_clr,
    output logic [2:0] bit_sel,
    output logic       out_valid,
    output logic       done,
    output logic       busy,
    output logic       err
);

    localparam int unsigned OL_W = 3;
    localparam int unsigned VC_W = 8;
    localparam int unsigned LB_W = 4;
    localparam int unsigned BS_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [LB_W-1:0] load_beat_n;
    logic [LB_W-1:0] load_last;
    logic [BS_W-1:0] bit_sel_n;
    logic [VC_W-1:0] vec_cnt;
    logic [VC_W-1:0] vec_cnt_n;
    logic [VC_W-1:0] vec_cnt_inc;
    logic [VC_W-1:0] vec_count_q;
    logic [VC_W-1:0] vec_count_n;
    logic [OL_W-1:0] out_len_q;
    logic [OL_W-1:0] out_len_n;
    logic            cfg_bad;
    logic            out_valid_n;
    logic            done_n;
    logic            err_n;
    logic            busy_n;

    // Datapath strobes follow the bus directly so a beat is consumed in the cycle it is offered.
    assign load_en  = in_valid && (state == LOAD);
    assign mult_en  = in_valid && (state == MULT);
    assign mult_clr = mult_en && (bit_sel == '0);

    // Index of the last weight beat for the latched row count.
    assign load_last   = LB_W'(WEIGHT_WIDTH) * LB_W'(out_len_q) - LB_W'(1);
    assign cfg_bad     = (cfg_out_len == '0) || (32'(cfg_out_len) > MAX_OUT_LEN);
    assign vec_cnt_inc = vec_cnt + VC_W'(1);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            load_beat   <= '0;
            bit_sel     <= '0;
            vec_cnt     <= '0;
            vec_count_q <= '0;
            out_len_q   <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            state       <= state_n;
            load_beat   <= load_beat_n;
            bit_sel     <= bit_sel_n;
            vec_cnt     <= vec_cnt_n;
            vec_count_q <= vec_count_n;
            out_len_q   <= out_len_n;
            out_valid   <= out_valid_n;
            done        <= done_n;
            err         <= err_n;
            busy        <= busy_n;
            in_ready    <= busy_n;
        end
    end

    // Next-state and counter logic; abort overrides every other event.
    always_comb begin
        state_n     = state;
        load_beat_n = load_beat;
        bit_sel_n   = bit_sel;
        vec_cnt_n   = vec_cnt;
        vec_count_n = vec_count_q;
        out_len_n   = out_len_q;
        out_valid_n = 1'b0;
        done_n      = 1'b0;
        err_n       = 1'b0;

        if (abort) begin
            state_n     = IDLE;
            load_beat_n = '0;
            bit_sel_n   = '0;
            vec_cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        out_len_n   = cfg_out_len;
                        vec_count_n = cfg_vec_count;
                        if (cfg_bad) begin
                            err_n = 1'b1;
                        end else begin
                            state_n     = LOAD;
                            load_beat_n = '0;
                        end
                    end
                end
                LOAD: begin
                    if (load_en) begin
                        if (load_beat == load_last) begin
                            state_n     = MULT;
                            load_beat_n = '0;
                            bit_sel_n   = '0;
                            vec_cnt_n   = '0;
                        end else begin
                            load_beat_n = load_beat + LB_W'(1);
                        end
                    end
                end
                MULT: begin
                    if (mult_en) begin
                        if (bit_sel == BS_W'(BIT_WIDTH - 1)) begin
                            bit_sel_n   = '0;
                            vec_cnt_n   = vec_cnt_inc;
                            out_valid_n = 1'b1;
                            // Zero vector count means continuous mode: counter wraps silently.
                            if ((vec_count_q != '0) && (vec_cnt_inc == vec_count_q)) begin
                                done_n    = 1'b1;
                                state_n   = IDLE;
                                vec_cnt_n = '0;
                            end
                        end else begin
                            bit_sel_n = bit_sel + BS_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Scoreboard bench for ternary_seq_ctrl: the stimulus side tracks the job as
// a count of accepted beats and pushes the strobes/pulses each cycle should
// show; an independent negedge monitor pops and compares.
module tb_ternary_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] cfg_out_len = '0;
    logic [7:0] cfg_vec_count = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       load_en;
    logic [3:0] load_beat;
    logic       mult_en;
    logic       mult_clr;
    logic [2:0] bit_sel;
    logic       out_valid;
    logic       done;
    logic       busy;
    logic       err;

    ternary_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_out_len(cfg_out_len), .cfg_vec_count(cfg_vec_count),
        .in_valid(in_valid), .in_ready(in_ready), .load_en(load_en),
        .load_beat(load_beat), .mult_en(mult_en), .mult_clr(mult_clr),
        .bit_sel(bit_sel), .out_valid(out_valid), .done(done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    localparam int K_LOAD = 0;
    localparam int K_MULT = 1;
    localparam int K_OUTV = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int kind;
        int idx;
        bit flag;
    } ev_t;

    ev_t exp_q[$];
    bit  exp_busy_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    // Reference job state: beats accepted so far, load length, vectors requested.
    bit m_busy = 0;
    int m_n = 0;
    int m_L = 0;
    int m_vecs = 0;
    bit pend_ov = 0;
    bit pend_done = 0;
    bit pend_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push(int k, int i, bit f);
        ev_t e;
        e.kind = k;
        e.idx  = i;
        e.flag = f;
        exp_q.push_back(e);
    endfunction

    function automatic bit take(int kind, string name, output ev_t e);
        e.kind = -1;
        e.idx  = 0;
        e.flag = 0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: event seen while scoreboard empty", name);
            return 0;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            n_fail++;
            $display("FAIL %s: got event kind %0d expected kind %0d", name, kind, e.kind);
            return 0;
        end
        return 1;
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin : mon
        ev_t e;
        bit  b;
        if (rst_n) begin
            if (exp_busy_q.size() > 0) begin
                b = exp_busy_q.pop_front();
                chk("busy", busy, b);
                chk("in_ready", in_ready, b);
            end
            if (out_valid || done) begin
                if (take(K_OUTV, "out_valid", e)) begin
                    chk("out_valid with done", out_valid, 1);
                    chk("done", done, e.flag);
                end
            end
            if (err) begin
                if (take(K_ERR, "err", e)) chk("err busy", busy, 0);
            end
            if (load_en) begin
                if (take(K_LOAD, "load_en", e)) chk("load_beat", load_beat, e.idx);
            end
            if (mult_en) begin
                if (take(K_MULT, "mult_en", e)) begin
                    chk("bit_sel", bit_sel, e.idx);
                    chk("mult_clr", mult_clr, e.flag);
                end
            end
        end
    end

    // One clock of stimulus plus the reference model's view of that cycle.
    task automatic step(input bit st, input bit ab, input bit iv, input int ol, input int vc);
        @(posedge clk);
        #1;
        start         = st;
        abort         = ab;
        in_valid      = iv;
        cfg_out_len   = 3'(ol);
        cfg_vec_count = 8'(vc);
        exp_busy_q.push_back(m_busy);
        if (pend_err) push(K_ERR, 0, 0);
        if (pend_ov) push(K_OUTV, 0, pend_done);
        pend_err  = 0;
        pend_ov   = 0;
        pend_done = 0;
        if (m_busy && iv) begin
            if (m_n < m_L) push(K_LOAD, m_n, 0);
            else push(K_MULT, (m_n - m_L) % 8, ((m_n - m_L) % 8) == 0);
        end
        if (ab) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (st) begin
                if (ol == 0 || ol > 7) begin
                    pend_err = 1;
                end else begin
                    m_busy = 1;
                    m_n    = 0;
                    m_L    = 2 * ol;
                    m_vecs = vc;
                end
            end
        end else if (iv) begin
            m_n++;
            if (m_n > m_L && ((m_n - m_L) % 8) == 0) begin
                pend_ov = 1;
                if (m_vecs != 0 && ((m_n - m_L) / 8) == m_vecs) begin
                    pend_done = 1;
                    m_busy    = 0;
                end
            end
        end
    endtask

    // mode 0: in_valid held high; 1: toggling 1010...; 2: random with stray starts/aborts.
    task automatic run_until_idle(input int mode, input int budget, input string name);
        int c;
        bit tog;
        bit iv;
        bit ab;
        bit st;
        c   = 0;
        tog = 1;
        while (m_busy && c < budget) begin
            st = 0;
            ab = 0;
            case (mode)
                0:       iv = 1;
                1:       iv = tog;
                default: begin
                    iv = ($urandom_range(0, 3) != 0);
                    st = ($urandom_range(0, 9) == 0);
                    ab = ($urandom_range(0, 63) == 0);
                end
            endcase
            tog = !tog;
            step(st, ab, iv, $urandom_range(0, 7), $urandom_range(0, 255));
            c++;
        end
        if (m_busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: job still running after %0d cycles", name, budget);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " load_en"}, load_en, 0);
        chk({tag, " load_beat"}, load_beat, 0);
        chk({tag, " mult_en"}, mult_en, 0);
        chk({tag, " mult_clr"}, mult_clr, 0);
        chk({tag, " bit_sel"}, bit_sel, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " err"}, err, 0);
    endtask

    task automatic drop_model();
        exp_q.delete();
        exp_busy_q.delete();
        m_busy    = 0;
        pend_ov   = 0;
        pend_done = 0;
        pend_err  = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ol;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // IDLE ignores the bus.
        idle_cycles(3);

        // Full job, no stalls.
        step(1, 0, 0, 7, 2);
        run_until_idle(0, 100, "full job");
        idle_cycles(3);

        // Same job with 1010 stalls.
        step(1, 0, 0, 7, 2);
        run_until_idle(1, 200, "stall job");
        idle_cycles(2);

        // Illegal config, legal job, illegal again.
        step(1, 0, 0, 0, 5);
        idle_cycles(2);
        step(1, 0, 0, 2, 1);
        run_until_idle(0, 100, "legal job");
        step(1, 0, 0, 0, 1);
        idle_cycles(2);

        // Abort on bit 7 of the first vector: no out_valid, no done.
        step(1, 0, 0, 1, 2);
        while (m_busy && m_n < m_L + 7) step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        idle_cycles(3);
        // abort and start together in IDLE: start ignored.
        step(1, 1, 0, 3, 1);
        idle_cycles(2);

        // Randomized jobs with stalls, stray starts and occasional aborts.
        for (int j = 0; j < 20; j++) begin
            ol = $urandom_range(0, 7);
            step(1, 0, $urandom_range(0, 1), ol, $urandom_range(1, 3));
            run_until_idle(2, 400, "random job");
            idle_cycles($urandom_range(1, 3));
        end

        // Continuous mode across the vector counter wrap.
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 2 + 260 * 8 + 3; i++) step(0, 0, 1, 0, 0);
        chk("continuous busy model", m_busy, 1);
        step(0, 1, 1, 0, 0);
        idle_cycles(2);

        // Reset mid-MULT with the bus still valid.
        step(1, 0, 0, 2, 3);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid-job reset");
        drop_model();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle_cycles(2);
        step(1, 0, 0, 3, 1);
        run_until_idle(0, 100, "post-reset job");
        idle_cycles(2);

        @(posedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
